id_hazard_scoreboard: RTL and testbench

- Parametrised operand-hazard unit for the decode stage.
- Generalises fixed EX/MEM/WB bypassing to NFWD priority-ordered forwarding sources.
- Adds a per-register scoreboard for out-of-order long-latency (LL) producers such as div/mod.
- Produces forwarded rj/rkd operands and the ID ready_go/stall decision. Sits between the regfile read ports and the ID→EX handshake.

---
 rtl/id_hazard_scoreboard.sv | 163 ++++++++++++++++
 tb/tb_id_hazard_scoreboard.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_scoreboard.sv
// Decode-stage operand forwarding, long-latency producer scoreboard and ID stall decision.
// Define HAZ_PERF_EN to add stall-cycle performance counters (ports are tied to 0 otherwise).
module id_hazard_scoreboard #(
    parameter int NREG   = 32,
    parameter int AW     = 5,
    parameter int DW     = 32,
    parameter int NFWD   = 3,
    parameter int LL_MAX = 4,
    parameter int CW     = 3
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               id_valid,
    input  logic               ex_allowin,
    output logic               id_ready_go,
    input  logic [AW-1:0]      rs1_addr,
    input  logic [AW-1:0]      rs2_addr,
    input  logic               rs1_need,
    input  logic               rs2_need,
    input  logic [DW-1:0]      rs1_rfdata,
    input  logic [DW-1:0]      rs2_rfdata,
    output logic [DW-1:0]      rs1_value,
    output logic [DW-1:0]      rs2_value,
    input  logic               id_we,
    input  logic [AW-1:0]      id_dest,
    input  logic               id_is_ll,
    input  logic [NFWD-1:0]    fwd_we,
    input  logic [NFWD*AW-1:0] fwd_addr,
    input  logic [NFWD*DW-1:0] fwd_data,
    input  logic [NFWD-1:0]    fwd_data_ok,
    input  logic               ll_done,
    input  logic [AW-1:0]      ll_addr,
    input  logic [DW-1:0]      ll_data,
    input  logic               sb_flush,
    output logic               sb_underflow,
    output logic               ll_full,
    output logic [31:0]        perf_ld_stall,
    output logic [31:0]        perf_ll_stall,
    output logic [31:0]        perf_full_stall
);

    logic [CW-1:0] pend_q [NREG];
    logic [CW-1:0] pend_d [NREG];
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic          underflow_q, underflow_d;

    logic [AW-1:0] rs_addr [2];
    logic [DW-1:0] rs_rf   [2];
    logic          rs_need [2];
    logic [DW-1:0] rs_val  [2];
    logic [1:0]    ld_hit, raw_hit;
    logic          ld_stall, ll_stall, waw_stall, full_stall, id_fire, ll_inc;

    assign rs_addr[0] = rs1_addr;
    assign rs_addr[1] = rs2_addr;
    assign rs_rf[0]   = rs1_rfdata;
    assign rs_rf[1]   = rs2_rfdata;
    assign rs_need[0] = rs1_need;
    assign rs_need[1] = rs2_need;
    assign rs1_value  = rs_val[0];
    assign rs2_value  = rs_val[1];

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            rs_val[s]  = rs_rf[s];
            ld_hit[s]  = 1'b0;
            raw_hit[s] = 1'b0;
            // Walk oldest to youngest so the youngest matching source wins.
            for (int i = NFWD - 1; i >= 0; i--) begin
                if (fwd_we[i] && fwd_addr[i*AW +: AW] == rs_addr[s]) begin
                    rs_val[s] = fwd_data[i*DW +: DW];
                    ld_hit[s] = rs_need[s] & ~fwd_data_ok[i];
                end
            end
            if (ll_done && ll_addr == rs_addr[s]) begin
                rs_val[s] = ll_data;
                ld_hit[s] = 1'b0;
            end else begin
                raw_hit[s] = rs_need[s] & (pend_q[rs_addr[s]] != '0);
            end
            if (rs_addr[s] == '0) begin
                rs_val[s]  = '0;
                ld_hit[s]  = 1'b0;
                raw_hit[s] = 1'b0;
            end
        end
    end

    assign ld_stall   = |ld_hit;
    assign ll_stall   = |raw_hit;
    // A single outstanding write that retires this cycle no longer blocks a new writer.
    assign waw_stall  = id_we && (id_dest != '0) && (pend_q[id_dest] != '0) &&
                        !(ll_done && ll_addr == id_dest && pend_q[id_dest] == CW'(1));
    assign full_stall = id_is_ll && (outstanding_q == CW'(LL_MAX)) && !ll_done;

    assign id_ready_go  = !id_valid || !(ld_stall || ll_stall || waw_stall || full_stall);
    assign id_fire      = id_valid & id_ready_go & ex_allowin;
    assign ll_inc       = id_fire & id_is_ll & (id_dest != '0);
    assign ll_full      = (outstanding_q == CW'(LL_MAX));
    assign sb_underflow = underflow_q;

    always_comb begin
        pend_d        = pend_q;
        outstanding_d = outstanding_q;
        underflow_d   = underflow_q;
        if (sb_flush) begin
            for (int r = 0; r < NREG; r++) pend_d[r] = '0;
            outstanding_d = '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (ll_inc && id_dest == AW'(r) && !(ll_done && ll_addr == AW'(r))) begin
                    pend_d[r] = pend_q[r] + 1'b1;
                end else if (ll_done && ll_addr == AW'(r) && !(ll_inc && id_dest == AW'(r))) begin
                    if (pend_q[r] == '0) underflow_d = 1'b1;
                    else                 pend_d[r]   = pend_q[r] - 1'b1;
                end
            end
            if (ll_inc && !ll_done) begin
                outstanding_d = outstanding_q + 1'b1;
            end else if (ll_done && !ll_inc) begin
                if (outstanding_q == '0) underflow_d   = 1'b1;
                else                     outstanding_d = outstanding_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < NREG; r++) pend_q[r] <= '0;
            outstanding_q <= '0;
            underflow_q   <= 1'b0;
        end else begin
            pend_q        <= pend_d;
            outstanding_q <= outstanding_d;
            underflow_q   <= underflow_d;
        end
    end

`ifdef HAZ_PERF_EN
    logic [31:0] perf_ld_q, perf_ll_q, perf_full_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_ld_q   <= '0;
            perf_ll_q   <= '0;
            perf_full_q <= '0;
        end else begin
            if (id_valid && ld_stall)   perf_ld_q   <= perf_ld_q + 32'd1;
            if (id_valid && ll_stall)   perf_ll_q   <= perf_ll_q + 32'd1;
            if (id_valid && full_stall) perf_full_q <= perf_full_q + 32'd1;
        end
    end

    assign perf_ld_stall   = perf_ld_q;
    assign perf_ll_stall   = perf_ll_q;
    assign perf_full_stall = perf_full_q;
`else
    assign perf_ld_stall   = '0;
    assign perf_ll_stall   = '0;
    assign perf_full_stall = '0;
`endif

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Bench for id_hazard_scoreboard: vector table, multi-cycle scoreboard sequences and
// randomized traffic against a behavioural model of the forwarding and scoreboard rules.
module tb_id_hazard_scoreboard;

    localparam int AW     = 5;
    localparam int DW     = 32;
    localparam int NFWD   = 3;
    localparam int LL_MAX = 4;

    logic               clk = 1'b0;
    logic               resetn;
    logic               id_valid, ex_allowin, id_ready_go;
    logic [AW-1:0]      rs1_addr, rs2_addr;
    logic               rs1_need, rs2_need;
    logic [DW-1:0]      rs1_rfdata, rs2_rfdata, rs1_value, rs2_value;
    logic               id_we, id_is_ll;
    logic [AW-1:0]      id_dest;
    logic [NFWD-1:0]    fwd_we, fwd_data_ok;
    logic [NFWD*AW-1:0] fwd_addr;
    logic [NFWD*DW-1:0] fwd_data;
    logic               ll_done;
    logic [AW-1:0]      ll_addr;
    logic [DW-1:0]      ll_data;
    logic               sb_flush, sb_underflow, ll_full;
    logic [31:0]        perf_ld_stall, perf_ll_stall, perf_full_stall;

    always #5 clk = ~clk;

    // Regfile stand-in: each register reads back a recognisable pattern.
    assign rs1_rfdata = 32'hC0DE_0000 | 32'(rs1_addr);
    assign rs2_rfdata = 32'hC0DE_0000 | 32'(rs2_addr);

    id_hazard_scoreboard dut (
        .clk(clk), .resetn(resetn), .id_valid(id_valid), .ex_allowin(ex_allowin),
        .id_ready_go(id_ready_go), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_need(rs1_need), .rs2_need(rs2_need), .rs1_rfdata(rs1_rfdata),
        .rs2_rfdata(rs2_rfdata), .rs1_value(rs1_value), .rs2_value(rs2_value),
        .id_we(id_we), .id_dest(id_dest), .id_is_ll(id_is_ll), .fwd_we(fwd_we),
        .fwd_addr(fwd_addr), .fwd_data(fwd_data), .fwd_data_ok(fwd_data_ok),
        .ll_done(ll_done), .ll_addr(ll_addr), .ll_data(ll_data), .sb_flush(sb_flush),
        .sb_underflow(sb_underflow), .ll_full(ll_full), .perf_ld_stall(perf_ld_stall),
        .perf_ll_stall(perf_ll_stall), .perf_full_stall(perf_full_stall)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_pend [32];
    int m_out;
    bit m_unf;
    int m_pld, m_pll, m_pfull;

    function automatic void model_reset();
        for (int r = 0; r < 32; r++) m_pend[r] = 0;
        m_out = 0; m_unf = 0; m_pld = 0; m_pll = 0; m_pfull = 0;
    endfunction

    function automatic logic [31:0] exp_val(input logic [AW-1:0] rs, input logic [31:0] rf);
        if (rs == 0) return 32'h0;
        if (ll_done && ll_addr == rs) return ll_data;
        for (int i = 0; i < NFWD; i++)
            if (fwd_we[i] && fwd_addr[i*AW +: AW] == rs) return fwd_data[i*DW +: DW];
        return rf;
    endfunction

    function automatic void terms(output bit ld, output bit raw, output bit waw, output bit full);
        logic [AW-1:0] rs;
        bit            need;
        ld = 0; raw = 0;
        for (int s = 0; s < 2; s++) begin
            rs   = (s == 0) ? rs1_addr : rs2_addr;
            need = (s == 0) ? rs1_need : rs2_need;
            if (need && rs != 0 && !(ll_done && ll_addr == rs)) begin
                for (int i = 0; i < NFWD; i++) begin
                    if (fwd_we[i] && fwd_addr[i*AW +: AW] == rs) begin
                        if (!fwd_data_ok[i]) ld = 1;
                        break;
                    end
                end
                if (m_pend[rs] != 0) raw = 1;
            end
        end
        waw  = id_we && id_dest != 0 && m_pend[id_dest] != 0 &&
               !(ll_done && ll_addr == id_dest && m_pend[id_dest] == 1);
        full = id_is_ll && m_out == LL_MAX && !ll_done;
    endfunction

    function automatic bit exp_ready();
        bit ld, raw, waw, full;
        terms(ld, raw, waw, full);
        return !id_valid || !(ld || raw || waw || full);
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    function automatic void model_step();
        bit ld, raw, waw, full, fire;
        terms(ld, raw, waw, full);
        fire = id_valid && exp_ready() && ex_allowin;
        if (id_valid) begin
            if (ld)   m_pld++;
            if (raw)  m_pll++;
            if (full) m_pfull++;
        end
        if (sb_flush) begin
            for (int r = 0; r < 32; r++) m_pend[r] = 0;
            m_out = 0;
        end else begin
            if (fire && id_is_ll && id_dest != 0) begin
                m_pend[id_dest]++;
                m_out++;
            end
            if (ll_done) begin
                if (ll_addr != 0) begin
                    if (m_pend[ll_addr] == 0) m_unf = 1;
                    else m_pend[ll_addr]--;
                end
                if (m_out == 0) m_unf = 1;
                else m_out--;
            end
        end
    endfunction

    task automatic check_model(input string tag);
        chk({tag, "_rs1"}, rs1_value, exp_val(rs1_addr, 32'hC0DE_0000 | 32'(rs1_addr)));
        chk({tag, "_rs2"}, rs2_value, exp_val(rs2_addr, 32'hC0DE_0000 | 32'(rs2_addr)));
        chk({tag, "_rdy"}, id_ready_go, exp_ready());
        chk({tag, "_full"}, ll_full, m_out == LL_MAX);
        chk({tag, "_unf"}, sb_underflow, m_unf);
`ifdef HAZ_PERF_EN
        chk({tag, "_pld"}, perf_ld_stall, m_pld);
        chk({tag, "_pll"}, perf_ll_stall, m_pll);
        chk({tag, "_pfull"}, perf_full_stall, m_pfull);
`else
        chk({tag, "_pld"}, perf_ld_stall, 0);
`endif
    endtask

    // ---------------- drivers ----------------
    task automatic idle();
        id_valid = 0; ex_allowin = 1; rs1_addr = 0; rs2_addr = 0; rs1_need = 0; rs2_need = 0;
        id_we = 0; id_dest = 0; id_is_ll = 0; fwd_we = 0; fwd_addr = 0; fwd_data = 0;
        fwd_data_ok = '1; ll_done = 0; ll_addr = 0; ll_data = 0; sb_flush = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1;
        tick();
    endtask

    task automatic issue(input logic [AW-1:0] dest, input logic we);
        idle();
        id_valid = 1; id_is_ll = 1; id_we = we; id_dest = dest;
    endtask

    task automatic reader(input logic [AW-1:0] rs);
        idle();
        id_valid = 1; rs1_addr = rs; rs1_need = 1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string              name;
        logic               valid;
        logic [AW-1:0]      rs1, rs2;
        logic               n1, n2;
        logic [NFWD-1:0]    we, ok;
        logic [NFWD*AW-1:0] addr;
        logic [NFWD*DW-1:0] data;
        logic [DW-1:0]      e1, e2;
        logic               erdy;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input string nm, input logic valid, input logic [AW-1:0] rs1,
                           input logic n1, input logic [AW-1:0] rs2, input logic n2,
                           input logic [NFWD-1:0] we, input logic [NFWD-1:0] ok,
                           input logic [NFWD*AW-1:0] addr, input logic [NFWD*DW-1:0] data,
                           input logic [DW-1:0] e1, input logic [DW-1:0] e2, input logic erdy);
        vec_t v;
        v.name = nm; v.valid = valid; v.rs1 = rs1; v.n1 = n1; v.rs2 = rs2; v.n2 = n2;
        v.we = we; v.ok = ok; v.addr = addr; v.data = data; v.e1 = e1; v.e2 = e2; v.erdy = erdy;
        vecs.push_back(v);
    endtask

    initial begin
        int cand[$];

        add_vec("fwd_youngest", 1, 5, 1, 0, 0, 3'b101, 3'b111, {5'd5, 5'd0, 5'd5},
                {32'h22, 32'h0, 32'h11}, 32'h11, 32'h0, 1);
        add_vec("load_use", 1, 0, 0, 7, 1, 3'b001, 3'b110, {5'd0, 5'd0, 5'd7},
                {32'h0, 32'h0, 32'h44}, 32'h0, 32'h44, 0);
        add_vec("load_in_fwd1", 1, 0, 0, 7, 1, 3'b010, 3'b111, {5'd0, 5'd7, 5'd0},
                {32'h0, 32'h33, 32'h0}, 32'h0, 32'h33, 1);
        add_vec("regfile", 1, 3, 1, 4, 1, 3'b000, 3'b111, {5'd3, 5'd4, 5'd3},
                {32'h1, 32'h2, 32'h3}, 32'hC0DE_0003, 32'hC0DE_0004, 1);
        add_vec("r0_zero", 1, 0, 1, 0, 1, 3'b001, 3'b000, {5'd0, 5'd0, 5'd0},
                {32'h0, 32'h0, 32'h55}, 32'h0, 32'h0, 1);
        add_vec("no_need", 1, 1, 0, 7, 0, 3'b001, 3'b000, {5'd0, 5'd0, 5'd7},
                {32'h0, 32'h0, 32'h44}, 32'hC0DE_0001, 32'h44, 1);
        add_vec("first_match_ok", 1, 6, 1, 0, 0, 3'b011, 3'b101, {5'd0, 5'd6, 5'd6},
                {32'h0, 32'h99, 32'h66}, 32'h66, 32'h0, 1);
        add_vec("we_gates_match", 1, 6, 1, 0, 0, 3'b100, 3'b110, {5'd6, 5'd0, 5'd6},
                {32'h77, 32'h0, 32'h88}, 32'h77, 32'h0, 1);
        add_vec("invalid_no_stall", 0, 0, 0, 7, 1, 3'b001, 3'b000, {5'd0, 5'd0, 5'd7},
                {32'h0, 32'h0, 32'h44}, 32'h0, 32'h44, 1);
        add_vec("load_fwd1_stall", 1, 8, 1, 0, 0, 3'b010, 3'b101, {5'd0, 5'd8, 5'd0},
                {32'h0, 32'h5A, 32'h0}, 32'h5A, 32'h0, 0);
        add_vec("both_from_wb", 1, 9, 1, 9, 1, 3'b100, 3'b111, {5'd9, 5'd0, 5'd0},
                {32'hBB, 32'h0, 32'h0}, 32'hBB, 32'hBB, 1);

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_ready", id_ready_go, 1);
        chk("rst_full", ll_full, 0);
        chk("rst_unf", sb_underflow, 0);
        chk("rst_perf", perf_ld_stall | perf_ll_stall | perf_full_stall, 0);
        tick();

        // Table vectors: no LL traffic, so the scoreboard stays empty throughout
        foreach (vecs[k]) begin
            idle();
            id_valid = vecs[k].valid; rs1_addr = vecs[k].rs1; rs1_need = vecs[k].n1;
            rs2_addr = vecs[k].rs2; rs2_need = vecs[k].n2; fwd_we = vecs[k].we;
            fwd_data_ok = vecs[k].ok; fwd_addr = vecs[k].addr; fwd_data = vecs[k].data;
            @(negedge clk);
            chk({vecs[k].name, "_rs1"}, rs1_value, vecs[k].e1);
            chk({vecs[k].name, "_rs2"}, rs2_value, vecs[k].e2);
            chk({vecs[k].name, "_rdy"}, id_ready_go, vecs[k].erdy);
            tick();
        end

        // Load-use resolves when the load reaches fwd1
        idle(); id_valid = 1; rs2_addr = 7; rs2_need = 1;
        fwd_we = 3'b001; fwd_addr = {5'd0, 5'd0, 5'd7}; fwd_data_ok = 3'b110;
        @(negedge clk); chk("lu_seq_stall", id_ready_go, 0); tick();
        fwd_we = 3'b010; fwd_addr = {5'd0, 5'd7, 5'd0}; fwd_data = {32'h0, 32'h33, 32'h0};
        fwd_data_ok = 3'b111;
        @(negedge clk); chk("lu_seq_val", rs2_value, 32'h33); chk("lu_seq_rdy", id_ready_go, 1);
        tick();

        // Divide to r9, RAW and WAW stalls until it writes back
        do_reset();
        issue(9, 1);
        @(negedge clk); chk("div_issue", id_ready_go, 1); tick();
        idle(); id_valid = 1; id_we = 1; id_dest = 9;
        @(negedge clk); chk("waw_stall", id_ready_go, 0); tick();
        reader(9); id_we = 1; id_dest = 10;
        @(negedge clk); chk("raw_stall", id_ready_go, 0); tick();
        @(negedge clk); chk("raw_stall_hold", id_ready_go, 0); tick();
        ll_done = 1; ll_addr = 9; ll_data = 32'hAB;
        @(negedge clk); chk("ll_bypass_val", rs1_value, 32'hAB); chk("ll_bypass_rdy", id_ready_go, 1);
        tick();
        reader(9); id_we = 1; id_dest = 9;
        @(negedge clk); chk("pend9_clear", id_ready_go, 1); chk("div_no_unf", sb_underflow, 0);
        tick();

        // Fill the LL unit, then free one slot in the same cycle as a fifth issue
        do_reset();
        for (int d = 1; d <= 4; d++) begin
            issue(AW'(d), 1);
            @(negedge clk); chk("ll_issue", id_ready_go, 1); tick();
        end
        issue(5, 1);
        @(negedge clk); chk("ll_full_set", ll_full, 1); chk("ll_full_stall", id_ready_go, 0); tick();
        @(negedge clk); chk("ll_full_hold", id_ready_go, 0); tick();
        ll_done = 1; ll_addr = 2; ll_data = 32'h2;
        @(negedge clk); chk("full_with_done", id_ready_go, 1); tick();
        idle();
        @(negedge clk); chk("outstanding_stays", ll_full, 1); tick();
        reader(2);
        @(negedge clk); chk("r2_released", id_ready_go, 1); tick();
        reader(5);
        @(negedge clk); chk("r5_pending", id_ready_go, 0); tick();

        // Underflow is sticky; flush clears pending counts but not the flag
        do_reset();
        idle(); ll_done = 1; ll_addr = 12;
        @(negedge clk); chk("underflow_not_yet", sb_underflow, 0); tick();
        idle();
        @(negedge clk); chk("underflow_set", sb_underflow, 1); tick();
        repeat (3) tick();
        @(negedge clk); chk("underflow_sticky", sb_underflow, 1); tick();
        issue(3, 1);
        @(negedge clk); chk("r3_issue_a", id_ready_go, 1); tick();
        issue(3, 0);
        @(negedge clk); chk("r3_issue_b", id_ready_go, 1); tick();
        reader(3);
        @(negedge clk); chk("r3_pending", id_ready_go, 0); tick();
        idle(); sb_flush = 1; tick();
        reader(3);
        @(negedge clk);
        chk("flush_clears", id_ready_go, 1);
        chk("unf_after_flush", sb_underflow, 1);
        chk("full_after_flush", ll_full, 0);
        tick();
        issue(3, 1); tick();
        idle(); id_valid = 1; id_we = 1; id_dest = 3; ll_done = 1; ll_addr = 3;
        @(negedge clk); chk("waw_exempt", id_ready_go, 1); tick();

        // Asynchronous reset with three LL ops outstanding
        do_reset();
        for (int d = 1; d <= 3; d++) begin issue(AW'(d), 1); tick(); end
        reader(1);
        @(negedge clk); chk("pre_reset_stall", id_ready_go, 0);
        #2 resetn = 0;
        #1 chk("async_reset_clear", id_ready_go, 1);
        chk("async_reset_full", ll_full, 0);
        chk("async_reset_perf", perf_ll_stall, 0);
        @(negedge clk); resetn = 1; model_reset(); tick();
        reader(2);
        @(negedge clk); chk("post_reset_r2", id_ready_go, 1); tick();

        // Five load-use stall cycles
        do_reset();
        idle(); id_valid = 1; rs2_addr = 7; rs2_need = 1;
        fwd_we = 3'b001; fwd_addr = {5'd0, 5'd0, 5'd7}; fwd_data_ok = 3'b110;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); chk("ld_stall_cycle", id_ready_go, 0); tick();
        end
        idle();
        @(negedge clk);
`ifdef HAZ_PERF_EN
        chk("perf_ld_5", perf_ld_stall, 5);
`else
        chk("perf_ld_tied", perf_ld_stall, 0);
`endif
        chk("perf_ll_0", perf_ll_stall, 0);
        chk("perf_full_0", perf_full_stall, 0);
        tick();

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 800; c++) begin
            idle();
            id_valid   = ($urandom_range(0, 3) != 0);
            ex_allowin = ($urandom_range(0, 3) != 0);
            rs1_addr   = AW'($urandom_range(0, 7));
            rs2_addr   = AW'($urandom_range(0, 7));
            rs1_need   = 1'($urandom_range(0, 1));
            rs2_need   = 1'($urandom_range(0, 1));
            id_we      = 1'($urandom_range(0, 1));
            id_dest    = AW'($urandom_range(0, 7));
            id_is_ll   = ($urandom_range(0, 2) == 0);
            fwd_we     = NFWD'($urandom_range(0, 7));
            fwd_data_ok = NFWD'($urandom_range(0, 7)) | NFWD'($urandom_range(0, 7));
            for (int i = 0; i < NFWD; i++) begin
                fwd_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
                fwd_data[i*DW +: DW] = $urandom;
            end
            cand = {};
            for (int r = 1; r < 32; r++) if (m_pend[r] > 0) cand.push_back(r);
            if (cand.size() > 0 && $urandom_range(0, 2) == 0) begin
                ll_done = 1;
                ll_addr = AW'(cand[$urandom_range(0, cand.size() - 1)]);
                ll_data = $urandom;
            end
            sb_flush = ($urandom_range(0, 60) == 0);
            @(negedge clk);
            check_model("rand");
            model_step();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
